sync_event_packer: RTL and testbench
====================================

SYNC_EVENT_PACKER -- requirements
Module: sync_event_packer

Interface
REQ-001 Parameter WIDTH, default 2: number of event bits; equals the downstream sync_fifo data width.
REQ-002 Parameter HOLD_CYCLES, default 0: gather window in cycles after the first event before a write; range 0..255.
REQ-003 Parameter GAP_CYCLES, default 8: minimum spacing in cycles between write_en pulses, sized so the reader drains a 4-entry FIFO; range 1..255.
REQ-004 clk  input  1  sole clock, the writer-side clock of the downstream FIFO.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 event_in  input  WIDTH  single-cycle event pulses; any bit pattern is legal every cycle.
REQ-007 write_en  output  1  one-cycle write strobe to the FIFO.
REQ-008 data_out  output  WIDTH  packed event word; valid while write_en=1, held otherwise.
REQ-009 busy  output  1  high when state is not IDLE or any pending bit is set.
REQ-010 coalesce_count  output  16  count of merged (coalesced) event cycles.

Function
REQ-011 States SHALL be IDLE, GATHER and COOLDOWN; write_en and data_out SHALL be registered.
REQ-012 The pending register SHALL OR in event_in every cycle and clear only at a write, where the captured word is pending|event_in.
REQ-013 IDLE with event_in!=0 and HOLD_CYCLES=0: at the next edge write_en=1, data_out=event_in, state=COOLDOWN, timer=GAP_CYCLES-1 (latency 1 cycle).
REQ-014 IDLE with event_in!=0 and HOLD_CYCLES>0: go to GATHER with timer=HOLD_CYCLES-1, and pending|=event_in.
REQ-015 GATHER with timer!=0 SHALL decrement the timer; with timer=0 it SHALL write pending|event_in and enter COOLDOWN with timer=GAP_CYCLES-1 (latency HOLD_CYCLES+1).
REQ-016 COOLDOWN with timer!=0 SHALL decrement the timer.
REQ-017 COOLDOWN with timer=0 and pending|event_in!=0 SHALL write immediately, with no gather, and reload the timer to GAP_CYCLES-1.
REQ-018 COOLDOWN with timer=0 and pending|event_in=0 SHALL return to IDLE.
REQ-019 Consecutive write_en pulses SHALL be at least GAP_CYCLES cycles apart; GAP_CYCLES=1 permits back-to-back writes.
REQ-020 An event arriving on the cycle its bit is captured for a write SHALL be included in that write and not re-sent.
REQ-021 An event arriving on the cycle after a write SHALL be pending for the next write.
REQ-022 No event SHALL ever be lost; repeated pulses of one bit before a write SHALL merge into a single 1.
REQ-023 data_out SHALL hold its last written value between writes.

Reset
REQ-024 reset=1 SHALL immediately force state=IDLE, write_en=0, data_out=0, pending=0, timers=0 and coalesce_count=0.
REQ-025 A reset mid-GATHER or mid-COOLDOWN SHALL discard pending events without emitting a write.
REQ-026 The first edge after reset deasserts SHALL evaluate event_in as in IDLE.

Configuration
REQ-027 With macro SYNC_EVENT_PACKER_COALESCE_COUNT_EN defined, coalesce_count SHALL increment by 1 in each cycle where (event_in & pending)!=0, saturating at 16'hFFFF.
REQ-028 Without SYNC_EVENT_PACKER_COALESCE_COUNT_EN, the coalesce_count port SHALL remain and be tied to 0, with no counter logic.

Structure
REQ-029 Package sync_event_pkg SHALL hold the state enum (IDLE, GATHER, COOLDOWN) and localparam TIMER_W=8.
REQ-030 One sub-module, sync_event_timer (a loadable 8-bit down-counter with zero flag), SHALL be instanced once and shared by GATHER and COOLDOWN.

Verification
REQ-031 HOLD=0, GAP=8; event_in=2'b01 at cycle 0 -> write_en at cycle 1 with data_out=01, busy high for cycles 1-8, then IDLE.
REQ-032 HOLD=3; event_in=01 at cycle 0 and 10 at cycle 2 -> a single write at cycle 4 with data_out=11.
REQ-033 HOLD=0, GAP=4; event_in=01 held for 12 cycles -> writes at cycles 1, 5, 9, 13, each with data_out=01; with the macro on, coalesce_count=8.
REQ-034 HOLD=0, GAP=8; event_in=10 one cycle after a write -> the next write occurs exactly 8 cycles after the first, with data_out=10.
REQ-035 Reset pulsed during COOLDOWN with pending=11 -> write_en=0 immediately, no write for 20 cycles, busy=0.
REQ-036 Build without the macro, repeat REQ-033 -> coalesce_count stays 0 and the write timing is unchanged.

Source files
------------

// File: rtl/sync_event_packer_pkg.sv
// Shared types and constants for the sync event packer: FSM state encoding,
// timer width and a helper that turns a cycle count into a timer reload value.
package sync_event_pkg;

  localparam int unsigned TIMER_W = 8;
  localparam int unsigned COUNT_W = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GATHER   = 2'd1,
    COOLDOWN = 2'd2
  } state_e;

  // A window of n cycles is counted as n-1 down to 0; a zero-length window loads 0.
  function automatic logic [TIMER_W-1:0] cycles_to_load(input int unsigned n);
    return (n == 0) ? '0 : TIMER_W'(n - 1);
  endfunction

endpackage

// File: rtl/sync_event_packer_timer.sv
// Loadable down-counter with a zero flag. One instance is shared by the gather
// window and the write-spacing cooldown; load takes priority over decrement.
module sync_event_timer
  import sync_event_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  input  logic               dec,
  output logic               zero
);

  logic [TIMER_W-1:0] count_q;
  logic [TIMER_W-1:0] count_d;

  // Next count: reload, or step down without wrapping below zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - TIMER_W'(1);
    end
  end

  // Counter register, cleared by the asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/sync_event_packer.sv
// Packs single-cycle event pulses into words written to a downstream FIFO.
// Events are ORed into a pending register; writes are optionally delayed by a
// gather window (HOLD_CYCLES) and always spaced by at least GAP_CYCLES cycles.
// Optional feature: define SYNC_EVENT_PACKER_COALESCE_COUNT_EN to count cycles in
// which an arriving event merged into an already-pending bit (saturating).
module sync_event_packer
  import sync_event_pkg::*;
#(
  parameter int unsigned WIDTH       = 2,
  parameter int unsigned HOLD_CYCLES = 0,
  parameter int unsigned GAP_CYCLES  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   event_in,
  output logic               write_en,
  output logic [WIDTH-1:0]   data_out,
  output logic               busy,
  output logic [COUNT_W-1:0] coalesce_count
);

  localparam logic [TIMER_W-1:0] HOLD_LOAD = cycles_to_load(HOLD_CYCLES);
  localparam logic [TIMER_W-1:0] GAP_LOAD  = cycles_to_load(GAP_CYCLES);

  state_e             state_q;
  state_e             state_d;
  logic [WIDTH-1:0]   pending_q;
  logic [WIDTH-1:0]   pending_d;
  logic               write_en_q;
  logic               write_en_d;
  logic [WIDTH-1:0]   data_out_q;
  logic [WIDTH-1:0]   data_out_d;
  logic [WIDTH-1:0]   merged;
  logic               tmr_load;
  logic [TIMER_W-1:0] tmr_load_val;
  logic               tmr_dec;
  logic               tmr_zero;

  sync_event_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  // FSM next state: pending always absorbs event_in; a write captures
  // pending|event_in and clears pending, so a same-cycle event is sent once.
  always_comb begin
    merged       = pending_q | event_in;
    state_d      = state_q;
    pending_d    = merged;
    write_en_d   = 1'b0;
    data_out_d   = data_out_q;
    tmr_load     = 1'b0;
    tmr_load_val = GAP_LOAD;
    tmr_dec      = 1'b0;

    case (state_q)
      IDLE: begin
        if (event_in != '0) begin
          if (HOLD_CYCLES == 0) begin
            write_en_d   = 1'b1;
            data_out_d   = merged;
            pending_d    = '0;
            state_d      = COOLDOWN;
            tmr_load     = 1'b1;
            tmr_load_val = GAP_LOAD;
          end else begin
            state_d      = GATHER;
            tmr_load     = 1'b1;
            tmr_load_val = HOLD_LOAD;
          end
        end
      end

      GATHER: begin
        if (!tmr_zero) begin
          tmr_dec = 1'b1;
        end else begin
          write_en_d   = 1'b1;
          data_out_d   = merged;
          pending_d    = '0;
          state_d      = COOLDOWN;
          tmr_load     = 1'b1;
          tmr_load_val = GAP_LOAD;
        end
      end

      COOLDOWN: begin
        if (!tmr_zero) begin
          tmr_dec = 1'b1;
        end else if (merged != '0) begin
          // Events collected during cooldown go out immediately, no new gather.
          write_en_d   = 1'b1;
          data_out_d   = merged;
          pending_d    = '0;
          tmr_load     = 1'b1;
          tmr_load_val = GAP_LOAD;
        end else begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d   = IDLE;
        pending_d = '0;
      end
    endcase
  end

  // FSM state, pending bits and registered write outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      write_en_q <= 1'b0;
      data_out_q <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      write_en_q <= write_en_d;
      data_out_q <= data_out_d;
    end
  end

  assign write_en = write_en_q;
  assign data_out = data_out_q;
  assign busy     = (state_q != IDLE) || (pending_q != '0);

`ifdef SYNC_EVENT_PACKER_COALESCE_COUNT_EN
  logic [COUNT_W-1:0] coalesce_q;
  logic [COUNT_W-1:0] coalesce_d;

  // Count cycles where an incoming event hits an already-pending bit.
  always_comb begin
    coalesce_d = coalesce_q;
    if (((event_in & pending_q) != '0) && (coalesce_q != '1)) begin
      coalesce_d = coalesce_q + COUNT_W'(1);
    end
  end

  // Coalesce counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      coalesce_q <= '0;
    end else begin
      coalesce_q <= coalesce_d;
    end
  end

  assign coalesce_count = coalesce_q;
`else
  assign coalesce_count = '0;
`endif

endmodule

// File: tb/tb_sync_event_packer.sv
// Self-checking bench for sync_event_packer. Four instances cover different
// HOLD/GAP settings; expected writes (cycle, data) are queued per instance as
// stimulus is driven and popped by a monitor whenever write_en is seen.
module tb_sync_event_packer;

  typedef struct {
    int unsigned cyc;
    logic [1:0]  data;
  } exp_t;

`ifdef SYNC_EVENT_PACKER_COALESCE_COUNT_EN
  localparam logic [15:0] CC_HELD = 16'd8;
  localparam logic [15:0] CC_SAME = 16'd1;
`else
  localparam logic [15:0] CC_HELD = 16'd0;
  localparam logic [15:0] CC_SAME = 16'd0;
`endif

  logic        clk;
  logic        rst;
  logic [1:0]  ev   [4];
  logic        we   [4];
  logic [1:0]  dout [4];
  logic        busy [4];
  logic [15:0] cc   [4];

  exp_t        exp_q [4][$];
  exp_t        mon_e;
  int unsigned cyc = 0;
  int          tests_run = 0;
  int          tests_failed = 0;

  // 0: HOLD=0 GAP=8, 1: HOLD=3 GAP=8, 2: HOLD=0 GAP=4, 3: HOLD=0 GAP=1
  sync_event_packer #(.WIDTH(2), .HOLD_CYCLES(0), .GAP_CYCLES(8)) u_a (
    .clk(clk), .reset(rst), .event_in(ev[0]), .write_en(we[0]),
    .data_out(dout[0]), .busy(busy[0]), .coalesce_count(cc[0]));
  sync_event_packer #(.WIDTH(2), .HOLD_CYCLES(3), .GAP_CYCLES(8)) u_b (
    .clk(clk), .reset(rst), .event_in(ev[1]), .write_en(we[1]),
    .data_out(dout[1]), .busy(busy[1]), .coalesce_count(cc[1]));
  sync_event_packer #(.WIDTH(2), .HOLD_CYCLES(0), .GAP_CYCLES(4)) u_c (
    .clk(clk), .reset(rst), .event_in(ev[2]), .write_en(we[2]),
    .data_out(dout[2]), .busy(busy[2]), .coalesce_count(cc[2]));
  sync_event_packer #(.WIDTH(2), .HOLD_CYCLES(0), .GAP_CYCLES(1)) u_d (
    .clk(clk), .reset(rst), .event_in(ev[3]), .write_en(we[3]),
    .data_out(dout[3]), .busy(busy[3]), .coalesce_count(cc[3]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: every observed write must match the next queued one.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i] === 1'b1) begin
          tests_run++;
          if (exp_q[i].size() == 0) begin
            tests_failed++;
            $display("FAIL unexpected_write dut%0d cycle=%0d data=%b required=no write", i, cyc, dout[i]);
          end else begin
            mon_e = exp_q[i].pop_front();
            if (cyc !== mon_e.cyc || dout[i] !== mon_e.data) begin
              tests_failed++;
              $display("FAIL write dut%0d got cycle=%0d data=%b required cycle=%0d data=%b",
                       i, cyc, dout[i], mon_e.cyc, mon_e.data);
            end
          end
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) ev[i] = 2'b00;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic check_drained(input int i, input string name);
    tests_run++;
    if (exp_q[i].size() != 0) begin
      tests_failed++;
      $display("FAIL %s_missing_write dut%0d got %0d outstanding required 0", name, i, exp_q[i].size());
      exp_q[i].delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) ev[i] = 2'b01;
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (we[i] !== 1'b0 || dout[i] !== 2'b00 || busy[i] !== 1'b0 || cc[i] !== 16'd0) begin
        tests_failed++;
        $display("FAIL reset_state dut%0d got we=%b data=%b busy=%b cc=%0d required 0/00/0/0",
                 i, we[i], dout[i], busy[i], cc[i]);
      end
    end
    for (int i = 0; i < 4; i++) ev[i] = 2'b00;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_single();
    int unsigned base;
    logic exp_busy;
    do_reset();
    @(posedge clk); #1;
    base = cyc;
    exp_q[0].push_back('{cyc: base + 1, data: 2'b01});
    for (int k = 0; k < 12; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      ev[0] = (k == 0) ? 2'b01 : 2'b00;
      @(negedge clk);
      exp_busy = (k >= 1 && k <= 8);
      tests_run++;
      if (busy[0] !== exp_busy) begin
        tests_failed++;
        $display("FAIL single_busy k=%0d got=%b required=%b", k, busy[0], exp_busy);
      end
    end
    tests_run++;
    if (dout[0] !== 2'b01) begin
      tests_failed++;
      $display("FAIL single_data_hold got=%b required=01", dout[0]);
    end
    check_drained(0, "single");
  endtask

  task automatic test_gather();
    int unsigned base;
    do_reset();
    @(posedge clk); #1;
    base = cyc;
    exp_q[1].push_back('{cyc: base + 4, data: 2'b11});
    for (int k = 0; k < 16; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      ev[1] = (k == 0) ? 2'b01 : (k == 2) ? 2'b10 : 2'b00;
      @(negedge clk);
    end
    tests_run++;
    if (busy[1] !== 1'b0) begin
      tests_failed++;
      $display("FAIL gather_idle got busy=%b required=0", busy[1]);
    end
    check_drained(1, "gather");
  endtask

  task automatic test_same_cycle();
    int unsigned base;
    do_reset();
    @(posedge clk); #1;
    base = cyc;
    exp_q[1].push_back('{cyc: base + 4, data: 2'b11});
    for (int k = 0; k < 20; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      ev[1] = (k == 0 || k == 1) ? 2'b01 : (k == 3) ? 2'b10 : 2'b00;
      @(negedge clk);
    end
    tests_run++;
    if (cc[1] !== CC_SAME) begin
      tests_failed++;
      $display("FAIL same_cycle_coalesce got=%0d required=%0d", cc[1], CC_SAME);
    end
    check_drained(1, "same_cycle");
  endtask

  task automatic test_coalesce();
    int unsigned base;
    do_reset();
    @(posedge clk); #1;
    base = cyc;
    for (int w = 0; w < 4; w++) exp_q[2].push_back('{cyc: base + 1 + 4 * w, data: 2'b01});
    for (int k = 0; k < 20; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      ev[2] = (k < 12) ? 2'b01 : 2'b00;
      @(negedge clk);
    end
    tests_run++;
    if (cc[2] !== CC_HELD) begin
      tests_failed++;
      $display("FAIL coalesce_count got=%0d required=%0d", cc[2], CC_HELD);
    end
    check_drained(2, "coalesce");
  endtask

  task automatic test_after_write();
    int unsigned base;
    do_reset();
    @(posedge clk); #1;
    base = cyc;
    exp_q[0].push_back('{cyc: base + 1, data: 2'b01});
    exp_q[0].push_back('{cyc: base + 9, data: 2'b10});
    for (int k = 0; k < 20; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      ev[0] = (k == 0) ? 2'b01 : (k == 2) ? 2'b10 : 2'b00;
      @(negedge clk);
    end
    check_drained(0, "after_write");
  endtask

  task automatic test_reset_cooldown();
    int unsigned base;
    do_reset();
    @(posedge clk); #1;
    base = cyc;
    exp_q[0].push_back('{cyc: base + 1, data: 2'b01});
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      ev[0] = (k == 2) ? 2'b11 : (k == 0) ? 2'b01 : 2'b00;
      @(negedge clk);
    end
    tests_run++;
    if (busy[0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL cooldown_busy got=%b required=1", busy[0]);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    tests_run++;
    if (we[0] !== 1'b0 || busy[0] !== 1'b0 || dout[0] !== 2'b00) begin
      tests_failed++;
      $display("FAIL midreset got we=%b busy=%b data=%b required 0/0/00", we[0], busy[0], dout[0]);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
    end
    tests_run++;
    if (busy[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL post_reset_busy got=%b required=0", busy[0]);
    end
    check_drained(0, "reset_cooldown");
  endtask

  task automatic test_back_to_back();
    int unsigned base;
    do_reset();
    @(posedge clk); #1;
    base = cyc;
    for (int w = 1; w <= 3; w++) exp_q[3].push_back('{cyc: base + w, data: 2'b01});
    exp_q[3].push_back('{cyc: base + 6, data: 2'b10});
    for (int k = 0; k < 12; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      ev[3] = (k < 3) ? 2'b01 : (k == 5) ? 2'b10 : 2'b00;
      @(negedge clk);
    end
    check_drained(3, "back_to_back");
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 4; i++) ev[i] = 2'b00;
    test_reset();
    test_single();
    test_gather();
    test_same_cycle();
    test_coalesce();
    test_after_write();
    test_reset_cooldown();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
